timeout_scheduler: RTL and testbench
====================================

// Module: timeout_scheduler
// PURPOSE
//  Multi-channel timeout scheduler driven by the shared tick pulses of the system TIMER block.
//  NUM_CH clients each request a countdown of VAL ticks in one unit (us/ms/s/min).
//  - A round-robin arbiter grants one load per cycle into the shared load path.
//  - Armed channels count their selected tick and pulse EXPIRE when the count runs out.
//  - Sits beside the TIMER instance; serves protocol retry/keep-alive logic.
// PARAMETERS
//  NUM_CH  4   number of client channels (2..8)
//  CNT_W   16  width of timeout value per channel
// PORTS
//  CLK        in   1             system clock (same clock as TIMER)
//  RST_N      in   1             reset, asynchronous, active-low
//  TIM_1US    in   1             1-cycle pulse every 1 us (from TIMER)
//  TIM_1MS    in   1             1-cycle pulse every 1 ms
//  TIM_1S     in   1             1-cycle pulse every 1 s
//  TIM_1M     in   1             1-cycle pulse every 1 min
//  REQ        in   NUM_CH        per-channel arm request, level, held until GNT
//  REQ_UNIT   in   2*NUM_CH      unit per channel: 0=us 1=ms 2=s 3=min
//  REQ_VAL    in   CNT_W*NUM_CH  tick count per channel, sampled on GNT
//  CANCEL     in   NUM_CH        1-cycle disarm request
//  GNT        out  NUM_CH        one-hot load grant, 1 cycle
//  BUSY       out  NUM_CH        channel armed
//  EXPIRE     out  NUM_CH        1-cycle timeout pulse
// BEHAVIOUR
//  Reset: GNT=0, BUSY=0, EXPIRE=0; all counters 0; RR pointer = channel 0.
//  Reset is asynchronous, deasserts synchronously via the usual reset synchroniser upstream.
//  Arbiter:
//  - Eligible set = REQ & ~CANCEL.
//  - Round-robin starts at the pointer; grants at most one channel per cycle.
//  - GNT is registered and asserted the cycle after REQ is seen.
//  - Pointer moves to granted index+1 (mod NUM_CH).
//  - A client drops REQ in the cycle GNT is seen; a REQ still high then is a new request.
//  Load, on the GNT edge:
//  - cnt <= REQ_VAL; unit <= REQ_UNIT; BUSY <= 1.
//  - VAL=0 is treated as 1.
//  - Granting an already-busy channel restarts it with the new value; no EXPIRE for the old run.
//  Channel states: IDLE -> ARMED (grant) -> IDLE (expire or cancel).
//  - ARMED: on the selected tick, cnt <= cnt-1. The tick on the load cycle itself is ignored.
//  - ARMED with cnt==1 and selected tick: next edge sets BUSY=0 and EXPIRE=1 for exactly 1 cycle.
//  - Hence the Nth qualifying tick after load expires the channel; EXPIRE lags the tick by 1 cycle.
//  Cancel:
//  - CANCEL on ARMED: next edge BUSY=0, cnt=0, no EXPIRE.
//  - Beats a simultaneous terminal tick.
//  - Beats and suppresses a same-cycle grant for that channel.
//  - CANCEL on IDLE is ignored.
//  Simultaneous events:
//  - Several channels may expire in the same cycle.
//  - Load and expire of different channels are independent.
//  - No counter ever wraps: the decrement is gated by cnt!=0.
//  Unit select is a 4:1 mux on the tick inputs; ticks coincide (1us/1ms/...) and need no special handling.
// STRUCTURE
//  Package tsch_pkg:
//  - localparams UNIT_US=2'd0, UNIT_MS=2'd1, UNIT_S=2'd2, UNIT_MIN=2'd3.
//  - channel state encoding ST_IDLE / ST_ARMED.
//  Sub-module timeout_sched_ch (one per channel, generate loop):
//  - holds cnt/unit/state; inputs load, val, unit, tick vector, cancel; outputs busy, expire.
//  - Round-robin arbiter and pointer stay in the top module.
// TESTING
//  1. Ch0: REQ, unit=us, VAL=3 -> GNT[0] 1 cycle later; EXPIRE[0] 1 cycle after 3rd TIM_1US; BUSY[0] high in between.
//  2. REQ=4'b1111 held, pointer=0 -> GNT order 0,1,2,3 on consecutive cycles; next round after ch2 re-request starts at 0.
//  3. Ch1 armed VAL=5 (ms), CANCEL[1] in the same cycle as its 5th TIM_1MS -> BUSY[1]=0, EXPIRE[1] never pulses.
//  4. Ch2 armed VAL=10 (us); after 4 ticks re-request VAL=2 -> no EXPIRE at the old 10th tick; EXPIRE 2 ticks after reload.
//  5. VAL=0, unit=s -> EXPIRE after the first TIM_1S, not before; tick coincident with GNT is not counted.
//  6. RST_N low mid-count on all channels -> BUSY/GNT/EXPIRE clear immediately (asynchronous); no EXPIRE after release.

Source files
------------

// File: rtl/tsch_pkg.sv
// Shared constants for the timeout scheduler: tick unit codes and channel state encoding.
package tsch_pkg;

    localparam logic [1:0] UNIT_US  = 2'd0;
    localparam logic [1:0] UNIT_MS  = 2'd1;
    localparam logic [1:0] UNIT_S   = 2'd2;
    localparam logic [1:0] UNIT_MIN = 2'd3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

endpackage

// File: rtl/timeout_sched_ch.sv
// One scheduler channel: loads a countdown on grant, counts its selected tick, pulses expire.
module timeout_sched_ch
    import tsch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic [1:0]       unit_i,
    input  logic [3:0]       tick_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             expire_o
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       unit_q, unit_d;
    logic             expire_q, expire_d;
    logic             tick_sel;

    always_comb begin
        tick_sel = 1'b0;
        case (unit_q)
            UNIT_US:  tick_sel = tick_i[0];
            UNIT_MS:  tick_sel = tick_i[1];
            UNIT_S:   tick_sel = tick_i[2];
            UNIT_MIN: tick_sel = tick_i[3];
            default:  tick_sel = 1'b0;
        endcase
    end

    // Cancel outranks both a pending load and a terminal tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        unit_d   = unit_q;
        expire_d = 1'b0;
        if (cancel_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (load_i) begin
            state_d = ST_ARMED;
            unit_d  = unit_i;
            cnt_d   = (val_i == '0) ? CNT_W'(1) : val_i;
        end else if (state_q == ST_ARMED && tick_sel && cnt_q != '0) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                expire_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            unit_q   <= UNIT_US;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            unit_q   <= unit_d;
            expire_q <= expire_d;
        end
    end

    assign busy_o   = (state_q == ST_ARMED);
    assign expire_o = expire_q;

endmodule

// File: rtl/timeout_scheduler.sv
// Multi-channel timeout scheduler: round-robin load arbiter feeding per-channel countdowns
// clocked by the shared TIMER tick pulses.
module timeout_scheduler
    import tsch_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    tim_1us_i,
    input  logic                    tim_1ms_i,
    input  logic                    tim_1s_i,
    input  logic                    tim_1m_i,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [2*NUM_CH-1:0]     req_unit_i,
    input  logic [CNT_W*NUM_CH-1:0] req_val_i,
    input  logic [NUM_CH-1:0]       cancel_i,
    output logic [NUM_CH-1:0]       gnt_o,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       expire_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] eligible;
    logic [3:0]        tick_vec;
    logic              found;
    int                idx;

    assign eligible = req_i & ~cancel_i;
    assign tick_vec = {tim_1m_i, tim_1s_i, tim_1ms_i, tim_1us_i};

    // Scan from the pointer; the first eligible channel wins and the pointer moves past it.
    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                gnt_d[idx] = 1'b1;
                ptr_d      = (idx == NUM_CH - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o = gnt_q;

    // The load happens at the end of the grant cycle, so REQ_VAL/REQ_UNIT are taken while GNT is high.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        timeout_sched_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .load_i   (gnt_q[gi]),
            .val_i    (req_val_i[gi*CNT_W +: CNT_W]),
            .unit_i   (req_unit_i[2*gi +: 2]),
            .tick_i   (tick_vec),
            .cancel_i (cancel_i[gi]),
            .busy_o   (busy_o[gi]),
            .expire_o (expire_o[gi])
        );
    end

endmodule

// File: tb/tb_timeout_scheduler.sv
// Directed bench for timeout_scheduler: grant order, countdown, cancel, reload, VAL=0, async reset.
module tb_timeout_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tim_1us = 1'b0, tim_1ms = 1'b0, tim_1s = 1'b0, tim_1m = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  req_unit = '0;
    logic [63:0] req_val = '0;
    logic [3:0]  cancel = '0;
    logic [3:0]  gnt, busy, expire;

    int nvec = 0;
    int nmis = 0;

    timeout_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .tim_1us_i  (tim_1us),
        .tim_1ms_i  (tim_1ms),
        .tim_1s_i   (tim_1s),
        .tim_1m_i   (tim_1m),
        .req_i      (req),
        .req_unit_i (req_unit),
        .req_val_i  (req_val),
        .cancel_i   (cancel),
        .gnt_o      (gnt),
        .busy_o     (busy),
        .expire_o   (expire)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] u, input logic [15:0] v);
        req_unit[2*ch +: 2] = u;
        req_val[16*ch +: 16] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (gnt !== 4'b0000) begin nmis++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL rst_busy: got %b want 0000", busy); end
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL rst_expire: got %b want 0000", expire); end
        rst_n = 1'b1;
        step();
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL rst_rel_busy: got %b want 0000", busy); end
        $display("test_reset done");
    endtask

    task automatic test_single_us();
        set_ch(0, 2'd0, 16'd3);
        req = 4'b0001;
        step();
        nvec++; if (gnt !== 4'b0001) begin nmis++; $display("FAIL t1_gnt: got %b want 0001", gnt); end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL t1_busy_pre: got %b want 0000", busy); end
        req = 4'b0000;
        step();
        nvec++; if (gnt !== 4'b0000) begin nmis++; $display("FAIL t1_gnt_off: got %b want 0000", gnt); end
        nvec++; if (busy !== 4'b0001) begin nmis++; $display("FAIL t1_busy_load: got %b want 0001", busy); end
        for (int k = 1; k <= 3; k++) begin
            tim_1us = 1'b1;
            step();
            tim_1us = 1'b0;
            nvec++; if (expire !== ((k == 3) ? 4'b0001 : 4'b0000)) begin nmis++; $display("FAIL t1_expire_tick%0d: got %b", k, expire); end
            nvec++; if (busy !== ((k == 3) ? 4'b0000 : 4'b0001)) begin nmis++; $display("FAIL t1_busy_tick%0d: got %b", k, busy); end
        end
        step();
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL t1_expire_width: got %b want 0000", expire); end
        $display("test_single_us done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 2'd3, 16'd100);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++; if (gnt !== exp_g[i]) begin nmis++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt, exp_g[i]); end
        end
        req = 4'b0101;
        step();
        nvec++; if (gnt !== 4'b0001) begin nmis++; $display("FAIL rr_wrap_gnt: got %b want 0001", gnt); end
        req = 4'b0100;
        step();
        nvec++; if (gnt !== 4'b0100) begin nmis++; $display("FAIL rr_next_gnt: got %b want 0100", gnt); end
        req = 4'b0000;
        step();
        nvec++; if (gnt !== 4'b0000) begin nmis++; $display("FAIL rr_idle_gnt: got %b want 0000", gnt); end
        nvec++; if (busy !== 4'b1111) begin nmis++; $display("FAIL rr_busy: got %b want 1111", busy); end
        cancel = 4'b1111;
        step();
        cancel = 4'b0000;
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL rr_cancel_busy: got %b want 0000", busy); end
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL rr_cancel_expire: got %b want 0000", expire); end
        $display("test_round_robin done");
    endtask

    task automatic test_cancel();
        set_ch(1, 2'd1, 16'd5);
        req = 4'b0010;
        step();
        nvec++; if (gnt !== 4'b0010) begin nmis++; $display("FAIL cx_gnt: got %b want 0010", gnt); end
        req = 4'b0000;
        step();
        for (int k = 1; k <= 4; k++) begin
            tim_1ms = 1'b1;
            step();
            tim_1ms = 1'b0;
            step();
        end
        nvec++; if (busy !== 4'b0010) begin nmis++; $display("FAIL cx_busy_armed: got %b want 0010", busy); end
        tim_1ms = 1'b1;
        cancel = 4'b0010;
        step();
        tim_1ms = 1'b0;
        cancel = 4'b0000;
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL cx_busy: got %b want 0000", busy); end
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL cx_expire: got %b want 0000", expire); end
        step();
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL cx_expire_late: got %b want 0000", expire); end
        req = 4'b1000;
        cancel = 4'b1000;
        step();
        req = 4'b0000;
        cancel = 4'b0000;
        nvec++; if (gnt !== 4'b0000) begin nmis++; $display("FAIL cx_grant_suppr: got %b want 0000", gnt); end
        step();
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL cx_grant_busy: got %b want 0000", busy); end
        $display("test_cancel done");
    endtask

    task automatic test_reload();
        set_ch(2, 2'd0, 16'd10);
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        nvec++; if (busy !== 4'b0100) begin nmis++; $display("FAIL rl_busy_first: got %b want 0100", busy); end
        repeat (4) begin
            tim_1us = 1'b1;
            step();
            tim_1us = 1'b0;
        end
        set_ch(2, 2'd0, 16'd2);
        req = 4'b0100;
        step();
        nvec++; if (gnt !== 4'b0100) begin nmis++; $display("FAIL rl_gnt: got %b want 0100", gnt); end
        req = 4'b0000;
        step();
        tim_1us = 1'b1;
        step();
        tim_1us = 1'b0;
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL rl_expire_early: got %b want 0000", expire); end
        nvec++; if (busy !== 4'b0100) begin nmis++; $display("FAIL rl_busy_mid: got %b want 0100", busy); end
        tim_1us = 1'b1;
        step();
        tim_1us = 1'b0;
        nvec++; if (expire !== 4'b0100) begin nmis++; $display("FAIL rl_expire: got %b want 0100", expire); end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL rl_busy_end: got %b want 0000", busy); end
        for (int k = 0; k < 6; k++) begin
            tim_1us = 1'b1;
            step();
            tim_1us = 1'b0;
            nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL rl_old_run%0d: got %b want 0000", k, expire); end
        end
        $display("test_reload done");
    endtask

    task automatic test_val_zero();
        set_ch(3, 2'd2, 16'd0);
        req = 4'b1000;
        step();
        nvec++; if (gnt !== 4'b1000) begin nmis++; $display("FAIL vz_gnt: got %b want 1000", gnt); end
        req = 4'b0000;
        tim_1s = 1'b1;
        step();
        tim_1s = 1'b0;
        nvec++; if (busy !== 4'b1000) begin nmis++; $display("FAIL vz_busy: got %b want 1000", busy); end
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL vz_expire_load: got %b want 0000", expire); end
        step();
        step();
        nvec++; if (busy !== 4'b1000) begin nmis++; $display("FAIL vz_busy_wait: got %b want 1000", busy); end
        tim_1s = 1'b1;
        step();
        tim_1s = 1'b0;
        nvec++; if (expire !== 4'b1000) begin nmis++; $display("FAIL vz_expire: got %b want 1000", expire); end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL vz_busy_end: got %b want 0000", busy); end
        $display("test_val_zero done");
    endtask

    task automatic arm_all(input logic [15:0] v);
        for (int c = 0; c < 4; c++) set_ch(c, 2'd0, v);
        req = 4'b1111;
        repeat (4) step();
        req = 4'b0000;
        step();
    endtask

    task automatic test_simultaneous();
        arm_all(16'd5);
        nvec++; if (busy !== 4'b1111) begin nmis++; $display("FAIL sim_busy: got %b want 1111", busy); end
        for (int k = 1; k <= 5; k++) begin
            tim_1us = 1'b1;
            step();
            tim_1us = 1'b0;
            nvec++; if (expire !== ((k == 5) ? 4'b1111 : 4'b0000)) begin nmis++; $display("FAIL sim_expire_tick%0d: got %b", k, expire); end
        end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL sim_busy_end: got %b want 0000", busy); end
        $display("test_simultaneous done");
    endtask

    task automatic test_async_reset();
        arm_all(16'd4);
        repeat (2) begin
            tim_1us = 1'b1;
            step();
            tim_1us = 1'b0;
        end
        req = 4'b0001;
        step();
        req = 4'b0000;
        nvec++; if (gnt !== 4'b0001) begin nmis++; $display("FAIL ar_gnt_pre: got %b want 0001", gnt); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (gnt !== 4'b0000) begin nmis++; $display("FAIL ar_gnt: got %b want 0000", gnt); end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL ar_busy: got %b want 0000", busy); end
        nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL ar_expire: got %b want 0000", expire); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tim_1us = 1'b1;
            step();
            tim_1us = 1'b0;
            nvec++; if (expire !== 4'b0000) begin nmis++; $display("FAIL ar_post_expire%0d: got %b want 0000", k, expire); end
        end
        nvec++; if (busy !== 4'b0000) begin nmis++; $display("FAIL ar_post_busy: got %b want 0000", busy); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single_us();
        test_round_robin();
        test_cancel();
        test_reload();
        test_val_zero();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
